io_ctrl: RTL
============

IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning bus data/address width.
REQ-002 SHALL provide parameter BE_W, default 4, meaning byte-enable width (DATA_W/8).
REQ-003 SHALL provide parameter N_TMR, default 2, meaning timer channel count, legal 1..8.
REQ-004 SHALL provide parameter LED_W, default 8, meaning LED output width, legal 1..DATA_W.
REQ-005 SHALL provide port clk  in  1  single system clock, all state on rising edge.
REQ-006 SHALL provide port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL provide port addr  in  DATA_W  byte address; only addr[7:2] (LSB-relative) decoded.
REQ-008 SHALL provide port wr  in  1  write strobe, one write per cycle high.
REQ-009 SHALL provide port BE  in  BE_W  byte enables for writes; byte k covers din bits 8k+7:8k.
REQ-010 SHALL provide port din  in  DATA_W  write data.
REQ-011 SHALL provide port dout  out  DATA_W  read data, combinational from addr and current state.
REQ-012 SHALL provide port LED_dis  out  LED_W  LED register contents.
REQ-013 SHALL provide port hw_int  out  1  registered level interrupt request.

Function
REQ-014 SHALL decode device select addr[7:4]: 0..N_TMR-1 = timer i; 0xE = LED; 0xF = interrupt controller; register offset = addr[3:2].
REQ-015 SHALL, per timer i, implement CTRL (off 0: bit0 EN, bit1 RELOAD, rest read 0), PRESET (off 1, DATA_W), COUNT (off 2, read-only).
REQ-016 SHALL merge every register write byte-wise under BE; bytes with BE=0 unchanged.
REQ-017 SHALL, on PRESET write, load COUNT with the new PRESET value in the same edge, overriding any decrement that cycle.
REQ-018 SHALL decrement COUNT by 1 each cycle when EN=1 and COUNT!=0.
REQ-019 SHALL, when EN=1 and COUNT==1, raise expire_i for exactly that edge: RELOAD=1 -> COUNT<=PRESET, EN kept; RELOAD=0 -> COUNT<=0, EN<=0.
REQ-020 SHALL hold COUNT when EN=0 or COUNT==0; never wrap below 0; auto-reload period = PRESET cycles; PRESET=0 never expires.
REQ-021 SHALL give a CTRL write precedence over the EN auto-clear in the same cycle.
REQ-022 SHALL implement LED register (off 0, LED_W bits), LED_dis = LED register.
REQ-023 SHALL implement PEND (off 0, N_TMR bits, bit i = timer i) set by expire_i, cleared by writing 1 (W1C, BE-qualified).
REQ-024 SHALL give set priority over W1C when both hit the same PEND bit in one cycle.
REQ-025 SHALL implement MASK (off 1, N_TMR bits, R/W); hw_int register <= |(PEND_next & MASK_next), so hw_int rises one edge after expiry.
REQ-026 SHALL return on dout the selected register zero-extended; unmapped select/offset returns all ones; writes to unmapped or read-only locations ignored.
REQ-027 SHALL keep dout independent of wr (read-during-write returns pre-write value).

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all CTRL, PRESET, COUNT, LED, PEND, MASK and hw_int to 0, ignoring wr.
REQ-029 SHALL, after reset mid-count, require re-programming; no expiry or interrupt generated from pre-reset state.
REQ-030 SHALL drive LED_dis=0, hw_int=0, dout per REQ-026 of zeroed state during and after reset.

Verification
REQ-031 SHALL test one-shot: timer0 PRESET=5, MASK=1, CTRL=EN -> expire 5 edges after enable, PEND=1, hw_int=1 next edge, COUNT=0, CTRL reads 0.
REQ-032 SHALL test reload: timer1 PRESET=3, CTRL=EN|RELOAD -> expire every 3 cycles, COUNT sequence 3,2,1,3,2,1.
REQ-033 SHALL test W1C: write PEND=1 on non-expiry cycle -> PEND=0, hw_int=0 next edge; same-cycle expiry and W1C -> PEND stays 1.
REQ-034 SHALL test byte enables: LED write din=0xFFFF_FFA5 BE=0001 over LED=0 -> LED_dis=0xA5; BE=0000 -> unchanged.
REQ-035 SHALL test masking/decode: MASK=0 with expiry -> PEND=1, hw_int=0; read addr select 0xA -> dout=0xFFFF_FFFF.
REQ-036 SHALL test reset mid-count: rst=1 at COUNT=2 with EN -> all registers 0, no expiry in following 10 cycles.

Source files
------------

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped timers, LED register and interrupt controller.
// Byte-enabled writes, combinational reads, registered level interrupt.
module io_ctrl #(
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int N_TMR  = 2,
  parameter int LED_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr,
  input  logic              wr,
  input  logic [BE_W-1:0]   BE,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LED_W-1:0]  LED_dis,
  output logic              hw_int
);

  localparam logic [3:0] SEL_LED = 4'hE;
  localparam logic [3:0] SEL_IC  = 4'hF;

  logic [3:0]        sel;
  logic [1:0]        off;
  logic [DATA_W-1:0] wmask;
  logic              unused_bits;

  logic              is_tmr;
  logic              is_led;
  logic              is_ic;

  logic [N_TMR-1:0]  tmr_hit;
  logic [N_TMR-1:0]  ctrl_we;
  logic [N_TMR-1:0]  preset_we;
  logic [N_TMR-1:0]  expire;

  logic [N_TMR-1:0]  en_q;
  logic [N_TMR-1:0]  en_d;
  logic [N_TMR-1:0]  rld_q;
  logic [N_TMR-1:0]  rld_d;
  logic [DATA_W-1:0] preset_q [N_TMR];
  logic [DATA_W-1:0] preset_d [N_TMR];
  logic [DATA_W-1:0] count_q  [N_TMR];
  logic [DATA_W-1:0] count_d  [N_TMR];

  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  led_d;
  logic [N_TMR-1:0]  pend_q;
  logic [N_TMR-1:0]  pend_d;
  logic [N_TMR-1:0]  pend_clr;
  logic [N_TMR-1:0]  mask_q;
  logic [N_TMR-1:0]  mask_d;
  logic              hw_int_d;

  assign sel = addr[7:4];
  assign off = addr[3:2];
  assign unused_bits = ^{addr[DATA_W-1:8], addr[1:0]};

  assign is_tmr = (sel < 4'(N_TMR));
  assign is_led = (sel == SEL_LED);
  assign is_ic  = (sel == SEL_IC);

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [DATA_W-1:0] m
  );
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Expand byte enables into a bit mask
  always_comb begin
    wmask = '0;
    for (int k = 0; k < BE_W; k++) begin
      wmask[8*k +: 8] = {8{BE[k]}};
    end
  end

  // Per-timer write strobes and expiry detection
  always_comb begin
    tmr_hit   = '0;
    ctrl_we   = '0;
    preset_we = '0;
    expire    = '0;
    for (int i = 0; i < N_TMR; i++) begin
      tmr_hit[i]   = (sel == 4'(i));
      ctrl_we[i]   = wr && tmr_hit[i] && (off == 2'd0);
      preset_we[i] = wr && tmr_hit[i] && (off == 2'd1);
      expire[i]    = en_q[i] && (count_q[i] == DATA_W'(1));
    end
  end

  // Timer next state: count down, expire, then apply register writes
  always_comb begin
    en_d  = en_q;
    rld_d = rld_q;
    for (int i = 0; i < N_TMR; i++) begin
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
      if (en_q[i] && (count_q[i] != '0)) begin
        if (expire[i]) begin
          if (rld_q[i]) begin
            count_d[i] = preset_q[i];
          end else begin
            count_d[i] = '0;
            en_d[i]    = 1'b0;
          end
        end else begin
          count_d[i] = count_q[i] - DATA_W'(1);
        end
      end
      if (ctrl_we[i] && BE[0]) begin
        en_d[i]  = din[0];
        rld_d[i] = din[1];
      end
      if (preset_we[i]) begin
        preset_d[i] = merge(preset_q[i], din, wmask);
        count_d[i]  = preset_d[i];
      end
    end
  end

  // LED, pending, mask and interrupt next state
  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    pend_clr = '0;
    if (wr && is_led && (off == 2'd0)) begin
      led_d = (led_q & ~wmask[LED_W-1:0])
            | (din[LED_W-1:0] & wmask[LED_W-1:0]);
    end
    if (wr && is_ic && (off == 2'd0)) begin
      pend_clr = din[N_TMR-1:0] & wmask[N_TMR-1:0];
    end
    if (wr && is_ic && (off == 2'd1)) begin
      mask_d = (mask_q & ~wmask[N_TMR-1:0])
             | (din[N_TMR-1:0] & wmask[N_TMR-1:0]);
    end
    pend_d   = (pend_q & ~pend_clr) | expire;
    hw_int_d = |(pend_d & mask_d);
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      rld_q <= '0;
      for (int i = 0; i < N_TMR; i++) begin
        preset_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      en_q  <= en_d;
      rld_q <= rld_d;
      for (int i = 0; i < N_TMR; i++) begin
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // LED, interrupt controller and hw_int registers
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      hw_int <= 1'b0;
    end else begin
      led_q  <= led_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      hw_int <= hw_int_d;
    end
  end

  assign LED_dis = led_q;

  // Read mux; anything unmapped reads as all ones
  always_comb begin
    dout = '1;
    unique case (1'b1)
      is_tmr: begin
        for (int i = 0; i < N_TMR; i++) begin
          if (tmr_hit[i]) begin
            unique case (off)
              2'd0:    dout = DATA_W'({rld_q[i], en_q[i]});
              2'd1:    dout = preset_q[i];
              2'd2:    dout = count_q[i];
              default: dout = '1;
            endcase
          end
        end
      end
      is_led: begin
        if (off == 2'd0) dout = DATA_W'(led_q);
      end
      is_ic: begin
        unique case (off)
          2'd0:    dout = DATA_W'(pend_q);
          2'd1:    dout = DATA_W'(mask_q);
          default: dout = '1;
        endcase
      end
      default: dout = '1;
    endcase
  end

endmodule
